// File: rtl/mac_array_acc_if.sv
// Operand/drain bus of the MAC array accumulator: beat input, drain stream and status.
// The master side drives operands and drain requests; the slave side is the MAC block.
interface mac_array_acc_if #(
    parameter int NUM_ROWS  = 16,
    parameter int ACC_DEPTH = 16,
    parameter int VEC_BITS  = 264,
    parameter int ACC_W     = 24
);
    localparam int COL_W = $clog2(ACC_DEPTH);

    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_ROWS*VEC_BITS-1:0] a_vec;
    logic [VEC_BITS-1:0]          b_vec;
    logic [1:0]                   mode;
    logic [COL_W-1:0]             acc_col;
    logic                         acc_clear;
    logic                         drain_start;
    logic                         out_valid;
    logic                         out_ready;
    logic [COL_W-1:0]             out_col;
    logic [NUM_ROWS*ACC_W-1:0]    out_data;
    logic                         ovf;
    logic                         busy;

    modport master (
        output in_valid, a_vec, b_vec, mode, acc_col, acc_clear, drain_start, out_ready,
        input  in_ready, out_valid, out_col, out_data, ovf, busy
    );

    modport slave (
        input  in_valid, a_vec, b_vec, mode, acc_col, acc_clear, drain_start, out_ready,
        output in_ready, out_valid, out_col, out_data, ovf, busy
    );
endinterface

// File: rtl/mac_array_acc.sv
// NUM_ROWS-lane INT8/INT4 dot-product engine accumulating into a NUM_ROWS x ACC_DEPTH
// saturating array, with a drain FSM that streams and clears every column.
module mac_array_acc #(
    parameter int NUM_ROWS  = 16,
    parameter int ACC_DEPTH = 16,
    parameter int VEC_BITS  = 264,
    parameter int ACC_W     = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_array_acc_if.slave bus
);
    localparam int COL_W = $clog2(ACC_DEPTH);
    localparam int DOT_W = 22;
    localparam int SUM_W = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACCUM, ST_WAIT, ST_DRAIN} state_t;

    state_t                    state_reg;
    logic                      s1_valid_reg;
    logic [COL_W-1:0]          s1_col_reg;
    logic                      s1_clear_reg;
    logic                      s2_valid_reg;
    logic [COL_W-1:0]          s2_col_reg;
    logic                      out_valid_reg;
    logic [COL_W-1:0]          out_col_reg;
    logic [NUM_ROWS*ACC_W-1:0] out_data_reg;
    logic                      ovf_reg;

    logic                      accept;
    logic                      fwd_hit;
    logic                      drain_take;
    logic                      last_col;
    logic [COL_W-1:0]          rd_col;
    logic [NUM_ROWS-1:0]       row_sat;
    logic [NUM_ROWS*ACC_W-1:0] rd_data;
    logic                      unused_b_scale;

    function automatic logic signed [DOT_W-1:0] dot_fn(
        input logic [255:0] a,
        input logic [255:0] b,
        input logic [1:0]   m
    );
        logic signed [DOT_W-1:0] acc;
        logic signed [7:0]       a8, b8;
        logic signed [3:0]       a4, b4;
        logic signed [15:0]      p;
        acc = '0;
        if (m == 2'b01) begin
            for (int k = 0; k < 32; k++) begin
                a8  = a[8*k +: 8];
                b8  = b[8*k +: 8];
                p   = 16'(a8) * 16'(b8);
                acc = acc + DOT_W'(p);
            end
        end else if (m == 2'b10) begin
            for (int k = 0; k < 64; k++) begin
                a4  = a[4*k +: 4];
                b4  = b[4*k +: 4];
                p   = 16'(a4) * 16'(b4);
                acc = acc + DOT_W'(p);
            end
        end
        return acc;
    endfunction

    assign accept     = bus.in_valid && (state_reg == ST_ACCUM);
    assign fwd_hit    = s2_valid_reg && (s2_col_reg == s1_col_reg);
    assign drain_take = (state_reg == ST_DRAIN) && out_valid_reg && bus.out_ready;
    assign last_col   = (out_col_reg == COL_W'(ACC_DEPTH-1));
    // Column to preload into out_data: 0 when entering the drain, else the next one.
    assign rd_col     = (state_reg == ST_DRAIN) ? out_col_reg + COL_W'(1) : '0;

    assign unused_b_scale = ^bus.b_vec[VEC_BITS-1:256];

    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : row_g
            logic signed [DOT_W-1:0] dot_comb;
            logic signed [DOT_W-1:0] s1_dot_reg;
            logic signed [ACC_W-1:0] old_val;
            logic signed [SUM_W-1:0] sum_full;
            logic signed [ACC_W-1:0] sat_val;
            logic                    sat_hi, sat_lo;
            logic signed [ACC_W-1:0] s2_sum_reg;
            logic signed [ACC_W-1:0] mem [ACC_DEPTH];
            logic                    unused_a_scale;

            assign unused_a_scale = ^bus.a_vec[gi*VEC_BITS+256 +: VEC_BITS-256];
            assign dot_comb = dot_fn(bus.a_vec[gi*VEC_BITS +: 256], bus.b_vec[255:0], bus.mode);

            // The S2 sum is not yet in mem when S1 targets the same column, so take it directly.
            always_comb begin
                old_val = '0;
                if (!s1_clear_reg) begin
                    old_val = fwd_hit ? s2_sum_reg : mem[s1_col_reg];
                end
                sum_full = $signed({{(SUM_W-ACC_W){old_val[ACC_W-1]}}, old_val})
                         + $signed({{(SUM_W-DOT_W){s1_dot_reg[DOT_W-1]}}, s1_dot_reg});
                sat_hi   = (sum_full > SAT_MAX);
                sat_lo   = (sum_full < SAT_MIN);
                if (sat_hi) begin
                    sat_val = SAT_MAX[ACC_W-1:0];
                end else if (sat_lo) begin
                    sat_val = SAT_MIN[ACC_W-1:0];
                end else begin
                    sat_val = sum_full[ACC_W-1:0];
                end
            end

            assign row_sat[gi] = sat_hi || sat_lo;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_dot_reg <= '0;
                    s2_sum_reg <= '0;
                end else begin
                    if (accept) begin
                        s1_dot_reg <= dot_comb;
                    end
                    if (s1_valid_reg) begin
                        s2_sum_reg <= sat_val;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < ACC_DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (s2_valid_reg) begin
                    mem[s2_col_reg] <= s2_sum_reg;
                end else if (drain_take) begin
                    mem[out_col_reg] <= '0;
                end
            end

            assign rd_data[gi*ACC_W +: ACC_W] = mem[rd_col];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_ACCUM;
            s1_valid_reg  <= 1'b0;
            s1_col_reg    <= '0;
            s1_clear_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_col_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_col_reg   <= '0;
            out_data_reg  <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_col_reg   <= bus.acc_col;
                s1_clear_reg <= bus.acc_clear;
            end
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_col_reg <= s1_col_reg;
                if (|row_sat) begin
                    ovf_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_ACCUM: begin
                    if (bus.drain_start) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Pipeline empty means every accepted beat has reached the array.
                    if (!s1_valid_reg && !s2_valid_reg) begin
                        state_reg     <= ST_DRAIN;
                        out_valid_reg <= 1'b1;
                        out_col_reg   <= '0;
                        out_data_reg  <= rd_data;
                    end
                end
                ST_DRAIN: begin
                    if (drain_take) begin
                        if (last_col) begin
                            state_reg     <= ST_ACCUM;
                            out_valid_reg <= 1'b0;
                            out_col_reg   <= '0;
                            out_data_reg  <= '0;
                            ovf_reg       <= 1'b0;
                        end else begin
                            out_col_reg  <= out_col_reg + COL_W'(1);
                            out_data_reg <= rd_data;
                        end
                    end
                end
                default: state_reg <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == ST_ACCUM);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_col   = out_col_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.busy      = s1_valid_reg || s2_valid_reg || (state_reg != ST_ACCUM);
endmodule

// File: tb/tb_mac_array_acc.sv
// Directed and random beats against a plain-arithmetic accumulator model; every column
// is compared as it is drained.
module tb_mac_array_acc;
    localparam int NR = 16;
    localparam int AD = 16;
    localparam int VB = 264;
    localparam int AW = 24;
    localparam longint SMAX = 64'sd8388607;
    localparam longint SMIN = -64'sd8388608;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_array_acc_if #(.NUM_ROWS(NR), .ACC_DEPTH(AD), .VEC_BITS(VB), .ACC_W(AW)) bus ();

    mac_array_acc #(.NUM_ROWS(NR), .ACC_DEPTH(AD), .VEC_BITS(VB), .ACC_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  errors = 0;
    int  checks = 0;
    int  model_acc [NR][AD];
    bit  model_ovf;

    task automatic chk(input string tag, input logic [NR*AW-1:0] obs, input logic [NR*AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint dot_ref(input logic [255:0] a, input logic [255:0] b, input logic [1:0] m);
        longint s = 0;
        int x, y;
        if (m == 2'b01) begin
            for (int k = 0; k < 32; k++) begin
                x = int'(a[k*8 +: 8]); if (x >= 128) x -= 256;
                y = int'(b[k*8 +: 8]); if (y >= 128) y -= 256;
                s += x * y;
            end
        end else if (m == 2'b10) begin
            for (int k = 0; k < 64; k++) begin
                x = int'(a[k*4 +: 4]); if (x >= 8) x -= 16;
                y = int'(b[k*4 +: 4]); if (y >= 8) y -= 16;
                s += x * y;
            end
        end
        return s;
    endfunction

    function automatic logic [NR*VB-1:0] rand_a();
        logic [NR*VB-1:0] v;
        for (int i = 0; i < NR*VB; i += 32) v[i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [VB-1:0] rand_b();
        logic [287:0] t;
        for (int i = 0; i < 288; i += 32) t[i +: 32] = $urandom;
        return t[VB-1:0];
    endfunction

    function automatic logic [VB-1:0] rep_byte(input logic [7:0] x);
        logic [VB-1:0] v;
        for (int k = 0; k < VB/8; k++) v[k*8 +: 8] = x;
        return v;
    endfunction

    // Drives a beat for the coming edge and applies it to the model.
    task automatic set_beat(input logic [NR*VB-1:0] a, input logic [VB-1:0] b,
                            input logic [1:0] m, input int col, input bit clr);
        longint s;
        bus.in_valid  = 1'b1;
        bus.a_vec     = a;
        bus.b_vec     = b;
        bus.mode      = m;
        bus.acc_col   = col[3:0];
        bus.acc_clear = clr;
        for (int r = 0; r < NR; r++) begin
            s = (clr ? 0 : longint'(model_acc[r][col])) + dot_ref(a[r*VB +: 256], b[255:0], m);
            if (s > SMAX) begin s = SMAX; model_ovf = 1'b1; end
            if (s < SMIN) begin s = SMIN; model_ovf = 1'b1; end
            model_acc[r][col] = int'(s);
        end
    endtask

    task automatic drain(input bit toggle, input int stop_col, input bit with_beat);
        int c = 0;
        int cyc = 0;
        int pat = 0;
        bit done = 0;
        bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [NR*AW-1:0] exp;
        int t;
        @(negedge clk);
        if (with_beat) set_beat(rand_a(), rand_b(), 2'b01, $urandom_range(0, AD-1), 1'($urandom_range(0, 1)));
        else bus.in_valid = 1'b0;
        bus.drain_start = 1'b1;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        bus.drain_start = 1'b0;
        chk("wait_in_ready", bus.in_ready, 0);
        // Beats offered while draining must be refused.
        bus.in_valid  = 1'b1;
        bus.a_vec     = rand_a();
        bus.mode      = 2'b01;
        bus.acc_clear = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.drain_start = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (c == stop_col) begin
                    done = 1;
                end else begin
                    for (int r = 0; r < NR; r++) begin
                        t = model_acc[r][c];
                        exp[r*AW +: AW] = t[AW-1:0];
                    end
                    chk("drain_col", bus.out_col, c);
                    chk("drain_data", bus.out_data, exp);
                    chk("drain_in_ready", bus.in_ready, 0);
                    bus.out_ready = toggle ? pattern[pat % 4] : 1'b1;
                    pat++;
                    if (c == 3) bus.drain_start = 1'b1;
                    if (bus.out_ready) begin
                        for (int r = 0; r < NR; r++) model_acc[r][c] = 0;
                        c++;
                        if (c == AD) begin
                            bus.in_valid = 1'b0;
                            model_ovf = 1'b0;
                            done = 1;
                        end
                    end
                end
            end
        end
        chk("drain_progress", c, stop_col);
        if (stop_col == AD) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("post_out_valid", bus.out_valid, 0);
            chk("post_in_ready", bus.in_ready, 1);
            chk("post_ovf", bus.ovf, model_ovf);
            chk("post_busy", bus.busy, 0);
            @(negedge clk);
            chk("post_busy2", bus.busy, 0);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NR*VB-1:0] a;
        bus.in_valid = 0; bus.a_vec = '0; bus.b_vec = '0; bus.mode = 2'b00;
        bus.acc_col = '0; bus.acc_clear = 0; bus.drain_start = 0; bus.out_ready = 0;
        for (int r = 0; r < NR; r++) for (int c = 0; c < AD; c++) model_acc[r][c] = 0;
        model_ovf = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // INT8: row0 all 0x02 x b all 0x03 into col 5
        @(negedge clk);
        a = rand_a();
        a[0 +: VB] = rep_byte(8'h02);
        set_beat(a, rep_byte(8'h03), 2'b01, 5, 1'b1);
        @(negedge clk);
        chk("busy_pipe", bus.busy, 1);
        set_beat(rand_a(), rand_b(), 2'b01, 9, 1'b1);
        drain(1'b0, AD, 1'b0);

        // INT4 back-to-back same column, then random back-to-back traffic
        @(negedge clk);
        set_beat({NR{rep_byte(8'hFF)}}, rep_byte(8'h77), 2'b10, 0, 1'b1);
        @(negedge clk);
        set_beat({NR{rep_byte(8'hFF)}}, rep_byte(8'h77), 2'b10, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            set_beat(rand_a(), rand_b(), 2'($urandom_range(0, 3)), $urandom_range(0, AD-1),
                     ($urandom_range(0, 3) == 0));
        end
        drain(1'b1, AD, 1'b0);
        drain(1'b0, AD, 1'b0);

        // Saturation on col 1
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_beat({NR{rep_byte(8'h7F)}}, rep_byte(8'h7F), 2'b01, 1, (i == 0));
        end
        @(negedge clk);
        idle(4);
        chk("sat_ovf", bus.ovf, model_ovf);
        chk("sat_busy", bus.busy, 0);
        drain(1'b0, AD, 1'b0);
        drain(1'b1, AD, 1'b0);

        // drain_start coinciding with a beat
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_beat(rand_a(), rand_b(), 2'($urandom_range(1, 2)), $urandom_range(0, AD-1), 1'b0);
        end
        drain(1'b1, AD, 1'b1);

        // Reset in the middle of a drain
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_beat({NR{rep_byte(8'h7F)}}, rep_byte(8'h7F), 2'b01, 2, (i == 0));
        end
        @(negedge clk);
        idle(4);
        chk("pre_rst_ovf", bus.ovf, 1);
        drain(1'b0, 7, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_ovf", bus.ovf, 0);
        chk("midrst_busy", bus.busy, 0);
        for (int r = 0; r < NR; r++) for (int c = 0; c < AD; c++) model_acc[r][c] = 0;
        model_ovf = 0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain(1'b0, AD, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
Parametrised successor to the 16-row MAC tile with accumulator latch array. Each accepted beat multiplies one shared B vector by NUM_ROWS A vectors in INT8 or INT4 mode. Each row's dot product is accumulated into an addressed column of an internal NUM_ROWS x ACC_DEPTH accumulator array, with saturation and forwarding. A drain FSM streams completed columns out over a valid/ready port, so the block sits between the operand fetch stage and the output writeback stage.

Parameters:
NUM_ROWS, 16, number of A rows (MAC lanes).
ACC_DEPTH, 16, accumulator columns per row (power of 2, >=2).
VEC_BITS, 264, bits per operand vector; [255:0] are elements, [VEC_BITS-1:256] are scale bits (ignored).
ACC_W, 24, signed accumulator width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
a_vec  in  NUM_ROWS*VEC_BITS  row r occupies [r*VEC_BITS +: VEC_BITS].
b_vec  in  VEC_BITS  shared operand.
mode  in  2  01=INT8, 10=INT4, 00/11=bypass (product 0); sampled with the beat.
acc_col  in  $clog2(ACC_DEPTH)  target column for the beat.
acc_clear  in  1  with beat: overwrite the column (old value treated as 0).
drain_start  in  1  pulse: stream all columns out, then clear them.
out_valid  out  1  drain data valid.
out_ready  in  1  downstream accepts drain data.
out_col  out  $clog2(ACC_DEPTH)  column index of out_data.
out_data  out  NUM_ROWS*ACC_W  row r at [r*ACC_W +: ACC_W].
ovf  out  1  sticky: any saturation since last drain completed.
busy  out  1  beat in pipeline or drain active.

Behaviour:
- Reset: all accumulators 0; out_valid=0, out_col=0, out_data=0, ovf=0, busy=0; FSM=ACCUM; pipeline valids=0. Reset mid-drain or mid-pipeline aborts immediately; no partial output.
- INT8: 32 signed 8-bit elements, element k = bits [8k+7:8k]; dot = sum a_k*b_k.
- INT4: 64 signed 4-bit elements, element k = bits [4k+3:4k].
- Dot product is computed at full width (>=21 bits), sign-extended, and added to the old value (0 if acc_clear). The sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation sets ovf.
- Pipeline: S1 registers the per-row dot products, col and clear on handshake (in_valid&&in_ready). S2 reads the column, adds, and writes. The write is visible 2 cycles after acceptance. Full throughput of 1 beat/cycle.
- Hazard: a beat in S1 hitting the same column being written in S2 uses the S2 result (forwarding). Back-to-back same-column beats must accumulate exactly.
- FSM ACCUM: in_ready=1. drain_start -> WAIT (a beat presented with drain_start in the same cycle is accepted first).
- FSM WAIT: in_ready=0 until S1/S2 are empty, then -> DRAIN with col=0.
- FSM DRAIN: in_ready=0. out_valid=1, out_col=col, out_data=array[col]. On out_valid&&out_ready, column col is zeroed and col increments. Once col=ACC_DEPTH-1 is taken: out_valid drops next cycle, ovf clears, FSM -> ACCUM.
- Under backpressure (out_ready=0), out_data/out_col stay stable.
- drain_start while not in ACCUM is ignored.
- busy = S1 valid | S2 valid | FSM!=ACCUM.

Test Plan:
- INT8: a row0 all 0x02, b all 0x03, col 5, clear -> after drain, row0 col5 = 192; other rows per their stimulus.
- INT4: a all 0xF (-1), b all 0x7, col 0, clear, then the same beat again back-to-back (forwarding) -> col0 = -896.
- Saturation: 400 INT8 beats of a=b=0x7F (+16129 x 32 each) to col 1 -> col1 = 8388607, ovf=1; ovf=0 after drain completes.
- Drain with out_ready toggling 1,0,0,1 over all 16 columns -> out_col 0..15 in order, data stable while stalled; all columns read 0 on a second drain.
- drain_start together with a valid beat -> beat accepted and included; in_ready low until the last column is taken, then high.
- Assert rst_n mid-drain at column 7 -> out_valid=0 and ovf=0 immediately; a subsequent drain returns all zeros.
